// File: rtl/adc_multi_bus_capture_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adc_multi_bus_capture_buffer                                  |
// | Purpose  : Arm/trigger capture of NUM_BUS ADC sample buses into per-bus  |
// |            RAM with per-bus readback and an input activity flag.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module adc_multi_bus_capture_buffer #(
    parameter int ADC_RESOLUTION   = 12,
    parameter int NUM_BUS          = 4,
    parameter int SAMPLES_PER_BEAT = 8,
    parameter int DEPTH            = 256,
    localparam int AW      = $clog2(DEPTH),
    localparam int BW      = SAMPLES_PER_BEAT * ADC_RESOLUTION,
    localparam int c_SEL_W = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1
) (
    input  logic                             app_clk,
    input  logic                             app_rst,
    input  logic [NUM_BUS-1:0]               bus_valid,
    input  logic [NUM_BUS*SAMPLES_PER_BEAT-1:0] bus_strb,
    input  logic [NUM_BUS*BW-1:0]            bus_data,
    input  logic                             arm,
    input  logic                             trig_mode,
    input  logic                             ext_trig,
    input  logic                             abort,
    input  logic                             rd_en,
    input  logic [c_SEL_W-1:0]               rd_bus,
    input  logic [AW-1:0]                    rd_addr,
    output logic [BW-1:0]                    rd_data,
    output logic                             rd_valid,
    output logic [NUM_BUS*(AW+1)-1:0]        wr_count,
    output logic                             busy,
    output logic                             done,
    output logic                             activity
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ARMED   = 2'd1;
    localparam logic [1:0] c_CAPTURE = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_stateNext;
    logic [NUM_BUS-1:0] w_full;
    logic               w_clrCount;
    logic               w_capture;
    logic               w_rdOk;
    logic [BW-1:0]      w_rdBeat [NUM_BUS];
    logic [BW-1:0]      w_rdSel;

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (abort) begin
            w_stateNext = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: if (arm) w_stateNext = c_ARMED;
                c_ARMED:        if (!trig_mode || ext_trig) w_stateNext = c_CAPTURE;
                c_CAPTURE:      if (&w_full) w_stateNext = c_DONE;
                default:        w_stateNext = c_IDLE;
            endcase
        end
    end

    // Counts clear on the transition into ARMED so they read 0 throughout ARMED.
    assign w_clrCount = (w_stateNext == c_ARMED) && (r_state != c_ARMED);
    assign w_capture  = (r_state == c_CAPTURE) && !abort && !app_rst;

    for (genvar b = 0; b < NUM_BUS; b++) begin : g_bus
        logic [AW:0]   r_count;
        logic [BW-1:0] r_mem [DEPTH];
        logic [BW-1:0] w_beat;
        logic          w_wrEn;

        always_comb begin
            w_beat = '0;
            for (int s = 0; s < SAMPLES_PER_BEAT; s++) begin
                if (bus_strb[b*SAMPLES_PER_BEAT+s]) begin
                    w_beat[s*ADC_RESOLUTION +: ADC_RESOLUTION] =
                        bus_data[b*BW + s*ADC_RESOLUTION +: ADC_RESOLUTION];
                end
            end
        end

        // MSB of the count set means DEPTH beats stored; later beats are dropped.
        assign w_full[b] = r_count[AW];
        assign w_wrEn    = w_capture && bus_valid[b] && !r_count[AW];

        always_ff @(posedge app_clk) begin
            if (app_rst || w_clrCount) begin
                r_count <= '0;
            end else if (w_wrEn) begin
                r_count <= r_count + (AW+1)'(1);
            end
        end

        always_ff @(posedge app_clk) begin
            if (w_wrEn) begin
                r_mem[r_count[AW-1:0]] <= w_beat;
            end
        end

        assign w_rdBeat[b] = r_mem[rd_addr];
        assign wr_count[b*(AW+1) +: (AW+1)] = r_count;
    end

    // An out-of-range bus select matches nothing and reads back as zero.
    always_comb begin
        w_rdSel = '0;
        for (int b = 0; b < NUM_BUS; b++) begin
            if (32'(rd_bus) == b) w_rdSel = w_rdBeat[b];
        end
    end

    assign w_rdOk = rd_en && ((r_state == c_IDLE) || (r_state == c_DONE));

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            activity <= 1'b0;
        end else begin
            rd_valid <= w_rdOk;
            if (w_rdOk) rd_data <= w_rdSel;
            activity <= (|bus_data) | (|bus_strb) | (|bus_valid);
        end
    end

    assign busy = (r_state == c_ARMED) || (r_state == c_CAPTURE);
    assign done = (r_state == c_DONE);

endmodule
`default_nettype wire
